multicycle_control_unit: RTL and testbench
==========================================

# multicycle_control_unit

Multi-cycle control sequencer directly upstream of `datapath`. It takes the fetched `instr` and the ALU `status` flags and drives every datapath control input on the correct cycle of each instruction: `pcsrc`, `alusrc`, `aluop`, `memrw`, `wb`, `regrw` and `immgen_ctrl`. It also provides PC/IR enables, a halt flag and a retired-instruction counter, replacing the hand-driven control sequences used in datapath bring-up.

## Interface
- `CNT_W`, default 32: width of the retired-instruction counter.
- `clk` input 1: sole clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `instr` input 32: instruction word from instruction memory; valid in FETCH.
- `status` input 5: ALU flags, combinational from the current `aluop`. Bit 0 = Z, 1 = N, 2 = C, 3 = V, 4 = reserved.
- `ir_en` output 1: datapath latches the instruction register this cycle.
- `pc_en` output 1: PC updates this cycle. Selects PC+4, or the branch target when `pcsrc`=1.
- `pcsrc` output 1: 1 selects the branch target.
- `alusrc` output 1: 1 selects the immediate as ALU operand B.
- `aluop` output 4: ALU operation code. 0000 ADD, 0001 XOR, 0010 AND, 0011 OR, 0100 NOR, 0101 SLL, 0110 SRL, 0111 SUB.
- `memrw` output 1: 1 writes data memory.
- `wb` output 1: 1 selects memory data for register writeback; 0 selects the ALU result.
- `regrw` output 1: register-file write enable.
- `immgen_ctrl` output 2: immediate format. 00 I, 01 S, 10 B, 11 reserved.
- `halted` output 1: sticky; set on an illegal instruction.
- `retired` output CNT_W: count of completed instructions.

## Operation
- State machine: FETCH → DECODE → EXEC → {MEM, WB, FETCH}; MEM → {WB, FETCH}; WB → FETCH; HALT (absorbing).
- FETCH: `ir_en`=1. The internal IR copy captures `instr`.
- DECODE: decode the IR copy into a registered control bundle.
  - Opcode 0110011 (R-type), funct3/funct7: 000/0000000 ADD, 000/0100000 SUB, 100 XOR, 111 AND, 110/0000000 OR, 110/0100000 NOR, 001 SLL, 101 SRL.
  - Opcode 0010011 (I-ALU): same funct3 map, with funct7 forced to 0 except for shifts.
  - Opcode 0000011: LW. Opcode 0100011: SW. Both require funct3 010.
  - Opcode 1100011 (branch), funct3: 000 BEQ, 001 BNE, 100 BLT, 101 BGE.
  - Any other encoding → HALT.
- EXEC: drive `aluop`, `alusrc`, `immgen_ctrl` from the bundle.
  - R-type: `alusrc`=0.
  - I-ALU and load: `alusrc`=1, `immgen_ctrl`=00, `aluop`=ADD.
  - Store: `alusrc`=1, `immgen_ctrl`=01, `aluop`=ADD.
  - Branch: `alusrc`=0, `aluop`=SUB, `immgen_ctrl`=10.
  - Branch condition: taken = Z (BEQ), !Z (BNE), N^V (BLT), !(N^V) (BGE). `pcsrc`=taken, `pc_en`=1, then → FETCH.
- MEM: holds the EXEC `aluop`/`alusrc`/`immgen_ctrl`.
  - Store: `memrw`=1, `pc_en`=1, then → FETCH.
  - Load: `memrw`=0, then → WB.
- WB: `regrw`=1, `pc_en`=1. `wb`=1 for loads, 0 for ALU ops. Holds the EXEC ALU controls.
- Instruction completion is `pc_en`=1. `retired` increments by one on each completion and wraps modulo 2^CNT_W.
- HALT: every control output is 0 and `halted`=1 until `rst`.
- Every control output not listed for a state is 0 in that state.

## Timing
- Cycles per instruction: branch 3, ALU 4, store 4, load 5.
- Control outputs are Moore: a function of the state register and the registered bundle only.
  - Exception: `pcsrc` in EXEC is combinational from `status`.
- `regrw`, `memrw` and `pc_en` are each asserted for exactly one cycle per instruction, never simultaneously with `ir_en`.
- The instruction is sampled only in FETCH. `instr` changes in other states are ignored.
- Reset: on a rising edge with `rst`=1, the next cycle has state=FETCH and `retired`=0. `halted` and all control outputs are 0 except `ir_en`=1.
- Reset mid-instruction (any state, including HALT) aborts the instruction with no `regrw`/`memrw` pulse and no `retired` increment.
- `rst` has priority over all transitions.

## Structure
- Shared package `ctrl_pkg` holds:
  - the state enum;
  - opcode and funct constants;
  - `aluop` codes;
  - `immgen_ctrl` codes;
  - status bit indices;
  - the packed control-bundle struct.
- Sub-module `ctrl_decode`: combinational, IR → {bundle, illegal}. The FSM and counter live in the top module.

## Test plan
- Reset: hold `rst` 2 cycles, then release → `ir_en`=1, all other controls 0, `retired`=0, `halted`=0.
- ADD x3,x1,x2 (0x002081B3):
  - EXEC: `aluop`=0000, `alusrc`=0.
  - WB (cycle 4): `regrw`=1, `wb`=0, `pc_en`=1.
  - Afterwards `retired`=1.
- LW x5,8(x1) (0x0080A283) → 5 cycles; `alusrc`=1, `immgen_ctrl`=00; WB has `wb`=1, `regrw`=1. Then SW x5,4(x1) (0x0050A223) → MEM has `memrw`=1, `immgen_ctrl`=01; `regrw` never asserted.
- BEQ x1,x2,+8 (0x00208463):
  - `status`=00001 in EXEC → `pcsrc`=1, `pc_en`=1 on cycle 3.
  - Repeat with `status`=00000 → `pcsrc`=0.
- Illegal 0xFFFFFFFF → HALT after DECODE, `halted`=1, all controls 0 for 10+ cycles, `retired` frozen; `rst` recovers.
- Assert `rst` during WB of an ADD → no `regrw` pulse, `retired` unchanged at 0, next state FETCH.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle control sequencer:
// FSM states, RV32 opcode/funct fields, ALU and immediate codes, control bundle.
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        CLS_ALU    = 2'd0,
        CLS_LOAD   = 2'd1,
        CLS_STORE  = 2'd2,
        CLS_BRANCH = 2'd3
    } instr_class_t;

    typedef enum logic [1:0] {
        BR_EQ = 2'd0,
        BR_NE = 2'd1,
        BR_LT = 2'd2,
        BR_GE = 2'd3
    } branch_cond_t;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_IALU   = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_SRL = 3'b101;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_LSW = 3'b010;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_XOR = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_NOR = 4'b0100;
    localparam logic [3:0] ALU_SLL = 4'b0101;
    localparam logic [3:0] ALU_SRL = 4'b0110;
    localparam logic [3:0] ALU_SUB = 4'b0111;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;

    localparam int STAT_Z = 0;
    localparam int STAT_N = 1;
    localparam int STAT_C = 2;
    localparam int STAT_V = 3;
    localparam int STAT_R = 4;

    typedef struct packed {
        instr_class_t cls;
        logic [3:0]   aluop;
        logic         alusrc;
        logic [1:0]   immgen;
        branch_cond_t br;
    } ctrl_bundle_t;

    // Signed compare uses N^V so it stays correct when the SUB overflows.
    function automatic logic branch_taken(input branch_cond_t br, input logic z,
                                          input logic n, input logic v);
        logic lt;
        lt = n ^ v;
        case (br)
            BR_EQ:   return z;
            BR_NE:   return !z;
            BR_LT:   return lt;
            default: return !lt;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder: IR fields to a control bundle plus an
// illegal flag for anything outside the supported RV32 subset.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [31:0]  ir,
    output ctrl_bundle_t bundle,
    output logic         illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [6:0] funct7_imm;
    logic [4:0] alu_r;
    logic [4:0] alu_i;
    logic       unused_fields;

    assign opcode = ir[6:0];
    assign funct3 = ir[14:12];
    assign funct7 = ir[31:25];
    assign unused_fields = ^{ir[24:15], ir[11:7]};

    // Returns {legal, aluop} for one funct3/funct7 pair.
    function automatic logic [4:0] alu_map(input logic [2:0] f3, input logic [6:0] f7);
        logic       base;
        logic       alt;
        logic [4:0] res;
        base = (f7 == F7_BASE);
        alt  = (f7 == F7_ALT);
        res  = {1'b0, ALU_ADD};
        case (f3)
            F3_ADD: begin
                if (base)     res = {1'b1, ALU_ADD};
                else if (alt) res = {1'b1, ALU_SUB};
            end
            F3_OR: begin
                if (base)     res = {1'b1, ALU_OR};
                else if (alt) res = {1'b1, ALU_NOR};
            end
            F3_XOR:  res = {base, ALU_XOR};
            F3_AND:  res = {base, ALU_AND};
            F3_SLL:  res = {base, ALU_SLL};
            F3_SRL:  res = {base, ALU_SRL};
            default: res = {1'b0, ALU_ADD};
        endcase
        return res;
    endfunction

    // Immediate forms carry immediate bits in funct7; only shifts interpret them.
    assign funct7_imm = (funct3 == F3_SLL || funct3 == F3_SRL) ? funct7 : F7_BASE;
    assign alu_r = alu_map(funct3, funct7);
    assign alu_i = alu_map(funct3, funct7_imm);

    always_comb begin
        bundle  = '{cls: CLS_ALU, aluop: ALU_ADD, alusrc: 1'b0, immgen: IMM_I, br: BR_EQ};
        illegal = 1'b0;
        case (opcode)
            OPC_RTYPE: begin
                bundle.aluop = alu_r[3:0];
                illegal      = !alu_r[4];
            end
            OPC_IALU: begin
                bundle.aluop  = alu_i[3:0];
                bundle.alusrc = 1'b1;
                illegal       = !alu_i[4];
            end
            OPC_LOAD: begin
                bundle.cls    = CLS_LOAD;
                bundle.alusrc = 1'b1;
                illegal       = (funct3 != F3_LSW);
            end
            OPC_STORE: begin
                bundle.cls    = CLS_STORE;
                bundle.alusrc = 1'b1;
                bundle.immgen = IMM_S;
                illegal       = (funct3 != F3_LSW);
            end
            OPC_BRANCH: begin
                bundle.cls    = CLS_BRANCH;
                bundle.aluop  = ALU_SUB;
                bundle.immgen = IMM_B;
                case (funct3)
                    F3_BEQ:  bundle.br = BR_EQ;
                    F3_BNE:  bundle.br = BR_NE;
                    F3_BLT:  bundle.br = BR_LT;
                    F3_BGE:  bundle.br = BR_GE;
                    default: illegal = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control sequencer for the datapath: FETCH/DECODE/EXEC/MEM/WB FSM,
// registered control bundle, sticky halt and retired-instruction counter.
module multicycle_control_unit
    import ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr,
    input  logic [4:0]       status,
    output logic             ir_en,
    output logic             pc_en,
    output logic             pcsrc,
    output logic             alusrc,
    output logic [3:0]       aluop,
    output logic             memrw,
    output logic             wb,
    output logic             regrw,
    output logic [1:0]       immgen_ctrl,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    state_t           state_reg;
    state_t           state_next;
    logic [31:0]      ir_reg;
    ctrl_bundle_t     bundle_reg;
    ctrl_bundle_t     dec_bundle;
    logic             dec_illegal;
    logic [CNT_W-1:0] retired_reg;
    logic             taken;
    logic             pc_en_moore;
    logic             memrw_moore;
    logic             regrw_moore;
    logic             unused_status;

    assign unused_status = status[STAT_C] ^ status[STAT_R];

    ctrl_decode u_decode (
        .ir      (ir_reg),
        .bundle  (dec_bundle),
        .illegal (dec_illegal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_FETCH;
            ir_reg      <= '0;
            bundle_reg  <= '0;
            retired_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_FETCH) begin
                ir_reg <= instr;
            end
            if (state_reg == ST_DECODE) begin
                bundle_reg <= dec_bundle;
            end
            if (pc_en) begin
                retired_reg <= retired_reg + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_FETCH:  state_next = ST_DECODE;
            ST_DECODE: state_next = dec_illegal ? ST_HALT : ST_EXEC;
            ST_EXEC: begin
                case (bundle_reg.cls)
                    CLS_BRANCH: state_next = ST_FETCH;
                    CLS_ALU:    state_next = ST_WB;
                    default:    state_next = ST_MEM;
                endcase
            end
            ST_MEM:    state_next = (bundle_reg.cls == CLS_LOAD) ? ST_WB : ST_FETCH;
            ST_WB:     state_next = ST_FETCH;
            ST_HALT:   state_next = ST_HALT;
            default:   state_next = ST_FETCH;
        endcase
    end

    assign taken = branch_taken(bundle_reg.br, status[STAT_Z], status[STAT_N], status[STAT_V]);

    always_comb begin
        ir_en       = 1'b0;
        pc_en_moore = 1'b0;
        pcsrc       = 1'b0;
        alusrc      = 1'b0;
        aluop       = ALU_ADD;
        memrw_moore = 1'b0;
        wb          = 1'b0;
        regrw_moore = 1'b0;
        immgen_ctrl = IMM_I;
        case (state_reg)
            ST_FETCH: ir_en = 1'b1;
            ST_EXEC: begin
                aluop       = bundle_reg.aluop;
                alusrc      = bundle_reg.alusrc;
                immgen_ctrl = bundle_reg.immgen;
                if (bundle_reg.cls == CLS_BRANCH) begin
                    pcsrc       = taken;
                    pc_en_moore = 1'b1;
                end
            end
            ST_MEM: begin
                aluop       = bundle_reg.aluop;
                alusrc      = bundle_reg.alusrc;
                immgen_ctrl = bundle_reg.immgen;
                if (bundle_reg.cls == CLS_STORE) begin
                    memrw_moore = 1'b1;
                    pc_en_moore = 1'b1;
                end
            end
            ST_WB: begin
                aluop       = bundle_reg.aluop;
                alusrc      = bundle_reg.alusrc;
                immgen_ctrl = bundle_reg.immgen;
                regrw_moore = 1'b1;
                pc_en_moore = 1'b1;
                wb          = (bundle_reg.cls == CLS_LOAD);
            end
            default: ;
        endcase
    end

    // Commit strobes are suppressed while rst is high so an aborted
    // instruction never writes state or counts as retired.
    assign pc_en   = pc_en_moore & ~rst;
    assign memrw   = memrw_moore & ~rst;
    assign regrw   = regrw_moore & ~rst;
    assign halted  = (state_reg == ST_HALT);
    assign retired = retired_reg;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: walks each instruction class
// cycle by cycle against hand-computed control vectors.
module tb_multicycle_control_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = '0;
    logic [4:0]  status = '0;
    logic        ir_en, pc_en, pcsrc, alusrc, memrw, wb, regrw, halted;
    logic [3:0]  aluop;
    logic [1:0]  immgen_ctrl;
    logic [31:0] retired;

    int          tests_run = 0;
    int          tests_failed = 0;
    logic [31:0] exp_retired = '0;

    // {ir_en, pc_en, pcsrc, alusrc, aluop[3:0], memrw, wb, regrw, immgen[1:0], halted}
    logic [13:0] ctl;
    assign ctl = {ir_en, pc_en, pcsrc, alusrc, aluop, memrw, wb, regrw, immgen_ctrl, halted};

    localparam logic [13:0] V_FETCH = 14'b1_0_0_0_0000_0_0_0_00_0;
    localparam logic [13:0] V_IDLE  = 14'b0_0_0_0_0000_0_0_0_00_0;
    localparam logic [13:0] V_HALT  = 14'b0_0_0_0_0000_0_0_0_00_1;
    localparam logic [13:0] V_WBSTB = 14'b0_1_0_0_0000_0_0_1_00_0;
    localparam logic [13:0] V_BR_T  = 14'b0_1_1_0_0111_0_0_0_10_0;
    localparam logic [13:0] V_BR_N  = 14'b0_1_0_0_0111_0_0_0_10_0;

    multicycle_control_unit #(.CNT_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr       (instr),
        .status      (status),
        .ir_en       (ir_en),
        .pc_en       (pc_en),
        .pcsrc       (pcsrc),
        .alusrc      (alusrc),
        .aluop       (aluop),
        .memrw       (memrw),
        .wb          (wb),
        .regrw       (regrw),
        .immgen_ctrl (immgen_ctrl),
        .halted      (halted),
        .retired     (retired)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tests_run++;
        if (ctl !== V_FETCH) begin
            tests_failed++;
            $display("FAIL reset_ctl got %b expected %b", ctl, V_FETCH);
        end
        tests_run++;
        if (retired !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_retired got %0d expected 0", retired);
        end
        $display("[TB] reset done");
    endtask

    task automatic test_alu();
        logic [31:0] ins [6];
        logic [13:0] ex  [6];
        ins = '{32'h002081B3, 32'h40208133, 32'h0020E1B3, 32'h4020E1B3, 32'h00508093, 32'hFFF08093};
        ex  = '{14'b0_0_0_0_0000_0_0_0_00_0, 14'b0_0_0_0_0111_0_0_0_00_0,
                14'b0_0_0_0_0011_0_0_0_00_0, 14'b0_0_0_0_0100_0_0_0_00_0,
                14'b0_0_0_1_0000_0_0_0_00_0, 14'b0_0_0_1_0000_0_0_0_00_0};
        for (int i = 0; i < 6; i++) begin
            instr  = ins[i];
            status = 5'b00001;
            tests_run++;
            if (ctl !== V_FETCH) begin
                tests_failed++;
                $display("FAIL alu_fetch[%0d] got %b expected %b", i, ctl, V_FETCH);
            end
            tick();
            instr = 32'hDEADBEEF;
            tests_run++;
            if (ctl !== V_IDLE) begin
                tests_failed++;
                $display("FAIL alu_decode[%0d] got %b expected %b", i, ctl, V_IDLE);
            end
            tick();
            tests_run++;
            if (ctl !== ex[i]) begin
                tests_failed++;
                $display("FAIL alu_exec[%0d] got %b expected %b", i, ctl, ex[i]);
            end
            tick();
            tests_run++;
            if (ctl !== (ex[i] | V_WBSTB)) begin
                tests_failed++;
                $display("FAIL alu_wb[%0d] got %b expected %b", i, ctl, ex[i] | V_WBSTB);
            end
            tick();
            exp_retired++;
            tests_run++;
            if (retired !== exp_retired || ctl !== V_FETCH) begin
                tests_failed++;
                $display("FAIL alu_retire[%0d] got %0d/%b expected %0d/%b",
                         i, retired, ctl, exp_retired, V_FETCH);
            end
            $display("[TB] alu instr %08h retired=%0d", ins[i], retired);
        end
    endtask

    task automatic test_load_store();
        logic [31:0] ins [2];
        logic [13:0] ex  [2][4];
        int          ncyc [2];
        // Per instruction: EXEC, MEM, WB (load only), then FETCH.
        ins  = '{32'h0080A283, 32'h0050A223};
        ncyc = '{3, 2};
        ex   = '{'{14'b0_0_0_1_0000_0_0_0_00_0, 14'b0_0_0_1_0000_0_0_0_00_0,
                   14'b0_1_0_1_0000_0_1_1_00_0, V_FETCH},
                 '{14'b0_0_0_1_0000_0_0_0_01_0, 14'b0_1_0_1_0000_1_0_0_01_0,
                   V_FETCH, V_FETCH}};
        for (int i = 0; i < 2; i++) begin
            instr  = ins[i];
            status = 5'b00000;
            tests_run++;
            if (ctl !== V_FETCH) begin
                tests_failed++;
                $display("FAIL ls_fetch[%0d] got %b expected %b", i, ctl, V_FETCH);
            end
            tick();
            instr = 32'hFFFFFFFF;
            tick();
            for (int c = 0; c <= ncyc[i]; c++) begin
                tests_run++;
                if (ctl !== ex[i][c]) begin
                    tests_failed++;
                    $display("FAIL ls_cycle[%0d][%0d] got %b expected %b", i, c, ctl, ex[i][c]);
                end
                if (c < ncyc[i]) tick();
            end
            exp_retired++;
            tests_run++;
            if (retired !== exp_retired) begin
                tests_failed++;
                $display("FAIL ls_retire[%0d] got %0d expected %0d", i, retired, exp_retired);
            end
            $display("[TB] mem instr %08h retired=%0d", ins[i], retired);
        end
    endtask

    task automatic test_branch();
        logic [31:0] ins [9];
        logic [4:0]  st  [9];
        logic        tk  [9];
        ins = '{32'h00208463, 32'h00208463, 32'h00209463, 32'h00209463, 32'h0020C463,
                32'h0020C463, 32'h0020D463, 32'h0020D463, 32'h00208463};
        st  = '{5'b00001, 5'b00000, 5'b00001, 5'b00000, 5'b00010,
                5'b01010, 5'b01010, 5'b01000, 5'b10100};
        tk  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 9; i++) begin
            instr  = ins[i];
            status = 5'b00000;
            tick();
            instr = 32'h00000000;
            tests_run++;
            if (ctl !== V_IDLE) begin
                tests_failed++;
                $display("FAIL br_decode[%0d] got %b expected %b", i, ctl, V_IDLE);
            end
            tick();
            status = st[i];
            #1;
            tests_run++;
            if (ctl !== (tk[i] ? V_BR_T : V_BR_N)) begin
                tests_failed++;
                $display("FAIL br_exec[%0d] got %b expected %b", i, ctl, tk[i] ? V_BR_T : V_BR_N);
            end
            tick();
            status = 5'b00000;
            exp_retired++;
            tests_run++;
            if (retired !== exp_retired || ctl !== V_FETCH) begin
                tests_failed++;
                $display("FAIL br_retire[%0d] got %0d/%b expected %0d/%b",
                         i, retired, ctl, exp_retired, V_FETCH);
            end
            $display("[TB] branch %08h status=%b taken=%b", ins[i], st[i], tk[i]);
        end
    endtask

    task automatic test_illegal();
        logic [31:0] ins [2];
        ins = '{32'hFFFFFFFF, 32'h022081B3};
        for (int i = 0; i < 2; i++) begin
            instr = ins[i];
            tick();
            tests_run++;
            if (ctl !== V_IDLE) begin
                tests_failed++;
                $display("FAIL ill_decode[%0d] got %b expected %b", i, ctl, V_IDLE);
            end
            tick();
            for (int c = 0; c < 12; c++) begin
                instr  = $urandom;
                status = 5'($urandom);
                #1;
                tests_run++;
                if (ctl !== V_HALT || retired !== exp_retired) begin
                    tests_failed++;
                    $display("FAIL ill_halt[%0d][%0d] got %b/%0d expected %b/%0d",
                             i, c, ctl, retired, V_HALT, exp_retired);
                end
                tick();
            end
            rst = 1'b1;
            tick();
            rst = 1'b0;
            status = 5'b00000;
            exp_retired = '0;
            tests_run++;
            if (ctl !== V_FETCH || retired !== 32'd0) begin
                tests_failed++;
                $display("FAIL ill_recover[%0d] got %b/%0d expected %b/0", i, ctl, retired, V_FETCH);
            end
            $display("[TB] illegal %08h halted and recovered", ins[i]);
        end
    endtask

    task automatic test_reset_mid_wb();
        instr = 32'h002081B3;
        tick();
        tick();
        tick();
        tests_run++;
        if (ctl !== V_WBSTB) begin
            tests_failed++;
            $display("FAIL midwb_wb got %b expected %b", ctl, V_WBSTB);
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if (regrw !== 1'b0 || pc_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL midwb_strobe got regrw=%b pc_en=%b expected 0 0", regrw, pc_en);
        end
        tick();
        rst = 1'b0;
        tests_run++;
        if (ctl !== V_FETCH || retired !== 32'd0) begin
            tests_failed++;
            $display("FAIL midwb_after got %b/%0d expected %b/0", ctl, retired, V_FETCH);
        end
        $display("[TB] reset during WB aborted, retired=%0d", retired);
    endtask

    initial begin
        #1;
        test_reset();
        test_alu();
        test_load_store();
        test_branch();
        test_illegal();
        test_reset_mid_wb();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
